// File: rtl/sgpr_rd_arbiter_if.sv
// Bundle of every valid/ready channel around the SGPR read arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// environment, which is the wavefront controllers plus the SGPR file.
interface sgpr_rd_arbiter_if #(
    parameter int NUM_WF     = 4,
    parameter int REQ_WIDTH  = 32,
    parameter int RESP_WIDTH = 64
);
    logic [NUM_WF-1:0]           wf_req_valid;
    logic [NUM_WF-1:0]           wf_req_ready;
    logic [NUM_WF*REQ_WIDTH-1:0] wf_req_data;
    logic                        sgpr_req_valid;
    logic                        sgpr_req_ready;
    logic [REQ_WIDTH-1:0]        sgpr_req_data;
    logic                        sgpr_resp_valid;
    logic                        sgpr_resp_ready;
    logic [RESP_WIDTH-1:0]       sgpr_resp_data;
    logic [NUM_WF-1:0]           wf_resp_valid;
    logic [NUM_WF-1:0]           wf_resp_ready;
    logic [RESP_WIDTH-1:0]       wf_resp_data;
    logic                        busy;
    logic                        err_unexp_resp;

    modport slave (
        input  wf_req_valid, wf_req_data, sgpr_req_ready,
        input  sgpr_resp_valid, sgpr_resp_data, wf_resp_ready,
        output wf_req_ready, sgpr_req_valid, sgpr_req_data,
        output sgpr_resp_ready, wf_resp_valid, wf_resp_data,
        output busy, err_unexp_resp
    );

    modport master (
        output wf_req_valid, wf_req_data, sgpr_req_ready,
        output sgpr_resp_valid, sgpr_resp_data, wf_resp_ready,
        input  wf_req_ready, sgpr_req_valid, sgpr_req_data,
        input  sgpr_resp_ready, wf_resp_valid, wf_resp_data,
        input  busy, err_unexp_resp
    );
endinterface

// File: rtl/sgpr_rd_arbiter.sv
// Round-robin arbiter that shares the single SGPR read port among NUM_WF wavefronts.
// The winning request is registered toward the SGPR file.
// The index of the requester goes into an in-order tag FIFO.
// Responses come back in request order, so the head tag routes each response combinationally.
module sgpr_rd_arbiter #(
    parameter int NUM_WF          = 4,
    parameter int REQ_WIDTH       = 32,
    parameter int RESP_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    sgpr_rd_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_WF);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

    logic [IDX_W-1:0]     r_rr_ptr;
    logic                 r_out_valid;
    logic [REQ_WIDTH-1:0] r_out_data;
    logic [IDX_W-1:0]     r_tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_err;

    logic                 w_found;
    logic [IDX_W-1:0]     w_grant;
    logic                 w_accept;
    logic                 w_nonempty;
    logic [IDX_W-1:0]     w_head;
    logic                 w_pop;
    logic [NUM_WF-1:0]    w_req_ready;
    logic [NUM_WF-1:0]    w_resp_valid;

    // Cyclic scan from rr_ptr: the first requesting wavefront becomes the candidate.
    always_comb begin
        logic [IDX_W-1:0] v_idx;
        logic             v_hit;
        w_found = 1'b0;
        w_grant = '0;
        v_idx   = '0;
        v_hit   = 1'b0;
        for (int k = 0; k < NUM_WF; k++) begin
            v_idx   = r_rr_ptr + IDX_W'(k);
            v_hit   = !w_found && bus.wf_req_valid[v_idx];
            w_grant = v_hit ? v_idx : w_grant;
            w_found = w_found | bus.wf_req_valid[v_idx];
        end
    end

    // A request is taken when the output slot frees up this cycle and a tag slot is free.
    // The tag check uses the registered count, so a same-cycle pop does not make room.
    assign w_accept = w_found && (!r_out_valid || bus.sgpr_req_ready) && (r_count < CNT_FULL);

    // Only the granted wavefront sees ready, and only when the request is accepted.
    always_comb begin
        w_req_ready          = '0;
        w_req_ready[w_grant] = w_accept;
    end

    assign w_nonempty = (r_count != '0);
    assign w_head     = r_tag_mem[r_rd_ptr];

    // Send the response valid to the wavefront named by the head tag.
    always_comb begin
        w_resp_valid         = '0;
        w_resp_valid[w_head] = bus.sgpr_resp_valid && w_nonempty;
    end

    assign w_pop = bus.sgpr_resp_valid && bus.sgpr_resp_ready;

    assign bus.wf_req_ready    = w_req_ready;
    assign bus.sgpr_req_valid  = r_out_valid;
    assign bus.sgpr_req_data   = r_out_data;
    assign bus.sgpr_resp_ready = w_nonempty && bus.wf_resp_ready[w_head];
    assign bus.wf_resp_valid   = w_resp_valid;
    assign bus.wf_resp_data    = bus.sgpr_resp_data;
    assign bus.busy            = r_out_valid || w_nonempty;
    assign bus.err_unexp_resp  = r_err;

    // Output register and round-robin pointer.
    // Data stays put while the SGPR file stalls the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.wf_req_data[w_grant*REQ_WIDTH +: REQ_WIDTH];
            r_rr_ptr    <= w_grant + IDX_W'(1);
        end else if (r_out_valid && bus.sgpr_req_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Tag FIFO of requester indices, in the order the requests were accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_tag_mem[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_tag_mem[r_wr_ptr] <= w_grant;
                r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag set by a response that arrives with no request outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (bus.sgpr_resp_valid && !w_nonempty) begin
            r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sgpr_rd_arbiter.sv
// Self-checking bench for sgpr_rd_arbiter.
// Every cycle is compared against a queue-based reference model.
// Hand-computed vector rows add checks on top of the model.
module tb_sgpr_rd_arbiter;
    localparam int NW = 4;
    localparam int RW = 32;
    localparam int PW = 64;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sgpr_rd_arbiter_if #(.NUM_WF(NW), .REQ_WIDTH(RW), .RESP_WIDTH(PW)) bus ();

    sgpr_rd_arbiter #(.NUM_WF(NW), .REQ_WIDTH(RW), .RESP_WIDTH(PW), .MAX_OUTSTANDING(MO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req_v;
        logic       sreq_rdy;
        logic       sresp_v;
        logic [3:0] resp_rdy;
        logic [3:0] e_req_rdy;
        logic       e_sreq_v;
        logic [3:0] e_resp_v;
        logic       e_sresp_rdy;
        logic       e_busy;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          m_rr = 0;
    bit          m_ov = 1'b0;
    logic [31:0] m_od = '0;
    int          m_q[$];
    bit          m_err = 1'b0;
    int          sgpr_pending = 0;

    vec_t tbl[10];
    vec_t nul;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] rv, input logic srd, input logic spv, input logic [3:0] rr,
                                input logic [3:0] erd, input logic esv, input logic [3:0] erv,
                                input logic esr, input logic eb);
        vec_t v;
        v.req_v = rv; v.sreq_rdy = srd; v.sresp_v = spv; v.resp_rdy = rr;
        v.e_req_rdy = erd; v.e_sreq_v = esv; v.e_resp_v = erv; v.e_sresp_rdy = esr; v.e_busy = eb;
        return v;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_ov = 1'b0; m_od = '0; m_q.delete(); m_err = 1'b0; sgpr_pending = 0;
    endtask

    // The caller drives inputs just after a posedge. This task checks at the negedge,
    // then advances the model at the next posedge.
    task automatic step(input bit use_tbl, input vec_t v, input string tag);
        int         g;
        int         h;
        int         sz;
        bit         acc;
        logic [3:0] rv;
        logic [3:0] e_rdy;
        logic [3:0] e_rv;
        bit         e_srdy;
        @(negedge clk);
        rv = bus.wf_req_valid;
        g  = 0;
        for (int k = NW - 1; k >= 0; k--) begin
            if (rv[(m_rr + k) % NW]) g = (m_rr + k) % NW;
        end
        sz     = m_q.size();
        acc    = (rv != 4'b0) && (!m_ov || bus.sgpr_req_ready) && (sz < MO);
        e_rdy  = acc ? 4'(1 << g) : 4'b0;
        h      = (sz != 0) ? m_q[0] : 0;
        e_rv   = (bus.sgpr_resp_valid && sz != 0) ? 4'(1 << h) : 4'b0;
        e_srdy = (sz != 0) && bus.wf_resp_ready[h];
        chk("wf_req_ready", 64'(bus.wf_req_ready), 64'(e_rdy));
        chk("sgpr_req_valid", 64'(bus.sgpr_req_valid), 64'(m_ov));
        if (m_ov) chk("sgpr_req_data", 64'(bus.sgpr_req_data), 64'(m_od));
        chk("wf_resp_valid", 64'(bus.wf_resp_valid), 64'(e_rv));
        chk("sgpr_resp_ready", 64'(bus.sgpr_resp_ready), 64'(e_srdy));
        chk("wf_resp_data", bus.wf_resp_data, bus.sgpr_resp_data);
        chk("busy", 64'(bus.busy), 64'(m_ov || sz != 0));
        chk("err_unexp_resp", 64'(bus.err_unexp_resp), 64'(m_err));
        if (use_tbl) begin
            chk({tag, ".req_rdy"}, 64'(bus.wf_req_ready), 64'(v.e_req_rdy));
            chk({tag, ".sreq_v"}, 64'(bus.sgpr_req_valid), 64'(v.e_sreq_v));
            chk({tag, ".resp_v"}, 64'(bus.wf_resp_valid), 64'(v.e_resp_v));
            chk({tag, ".sresp_rdy"}, 64'(bus.sgpr_resp_ready), 64'(v.e_sresp_rdy));
            chk({tag, ".busy"}, 64'(bus.busy), 64'(v.e_busy));
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (bus.sgpr_resp_valid && e_srdy) begin
                void'(m_q.pop_front());
                if (sgpr_pending > 0) sgpr_pending--;
            end
            if (bus.sgpr_resp_valid && sz == 0) m_err = 1'b1;
            if (m_ov && bus.sgpr_req_ready) sgpr_pending++;
            if (acc) begin
                m_q.push_back(g);
                m_od = bus.wf_req_data[g*RW +: RW];
                m_ov = 1'b1;
                m_rr = (g + 1) % NW;
            end else if (m_ov && bus.sgpr_req_ready) begin
                m_ov = 1'b0;
            end
        end
        #1;
    endtask

    task automatic apply(input vec_t v, input logic [63:0] rdata, input string tag);
        bus.wf_req_valid    = v.req_v;
        bus.sgpr_req_ready  = v.sreq_rdy;
        bus.sgpr_resp_valid = v.sresp_v;
        bus.wf_resp_ready   = v.resp_rdy;
        bus.sgpr_resp_data  = rdata;
        step(1'b1, v, tag);
    endtask

    initial begin
        //          req_v  srdy  spv   resp_rdy | e_req_rdy e_sv e_resp_v e_srdy e_busy
        tbl[0] = mk(4'hF, 1'b1, 1'b0, 4'hF,  4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
        tbl[1] = mk(4'hF, 1'b1, 1'b0, 4'hF,  4'b0010, 1'b1, 4'b0000, 1'b1, 1'b1);
        tbl[2] = mk(4'hF, 1'b1, 1'b1, 4'hF,  4'b0100, 1'b1, 4'b0001, 1'b1, 1'b1);
        tbl[3] = mk(4'hF, 1'b1, 1'b0, 4'hF,  4'b1000, 1'b1, 4'b0000, 1'b1, 1'b1);
        tbl[4] = mk(4'hF, 1'b1, 1'b0, 4'hF,  4'b0001, 1'b1, 4'b0000, 1'b1, 1'b1);
        tbl[5] = mk(4'hF, 1'b1, 1'b1, 4'hD,  4'b0000, 1'b1, 4'b0010, 1'b0, 1'b1);
        tbl[6] = mk(4'hF, 1'b1, 1'b1, 4'hF,  4'b0000, 1'b0, 4'b0010, 1'b1, 1'b1);
        tbl[7] = mk(4'hF, 1'b1, 1'b0, 4'hF,  4'b0010, 1'b0, 4'b0000, 1'b1, 1'b1);
        tbl[8] = mk(4'h0, 1'b0, 1'b0, 4'hF,  4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1);
        tbl[9] = mk(4'h4, 1'b0, 1'b0, 4'hF,  4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1);
        nul    = mk(4'h0, 1'b0, 1'b0, 4'h0,  4'h0, 1'b0, 4'h0, 1'b0, 1'b0);

        bus.wf_req_valid    = '0;
        bus.wf_req_data     = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        bus.sgpr_req_ready  = 1'b0;
        bus.sgpr_resp_valid = 1'b0;
        bus.sgpr_resp_data  = '0;
        bus.wf_resp_ready   = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step(1'b1, nul, "reset");

        // Round-robin order, the tag FIFO filling, head backpressure and a stalled request.
        rst = 1'b0;
        for (int r = 0; r < 10; r++) begin
            apply(tbl[r], 64'hD000_0000_0000_0000 + 64'(r), $sformatf("vec%0d", r));
        end

        // With only wf2 requesting, wf2 is granted. With everyone requesting, wf3 follows.
        rst = 1'b1;
        step(1'b0, nul, "rst");
        rst = 1'b0;
        apply(mk(4'h4, 1'b1, 1'b0, 4'hF, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0), 64'h1, "wf2a");
        apply(mk(4'h4, 1'b1, 1'b0, 4'hF, 4'b0100, 1'b1, 4'b0000, 1'b1, 1'b1), 64'h2, "wf2b");
        apply(mk(4'hF, 1'b1, 1'b0, 4'hF, 4'b1000, 1'b1, 4'b0000, 1'b1, 1'b1), 64'h3, "wf3");

        // A response with no request outstanding sets a sticky error that only rst clears.
        rst = 1'b1;
        step(1'b0, nul, "rst");
        rst = 1'b0;
        apply(mk(4'h0, 1'b1, 1'b1, 4'hF, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0), 64'h55, "unexp");
        apply(nul, 64'h0, "idle1");
        apply(nul, 64'h0, "idle2");
        chk("err_sticky", 64'(bus.err_unexp_resp), 64'd1);
        rst = 1'b1;
        step(1'b0, nul, "rst");
        rst = 1'b0;
        chk("err_cleared", 64'(bus.err_unexp_resp), 64'd0);
        chk("busy_cleared", 64'(bus.busy), 64'd0);

        // Random traffic checked against the model. The SGPR side only answers requests it has taken.
        rst = 1'b1;
        step(1'b0, nul, "rst");
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rst                 = ($urandom_range(0, 149) == 0);
            bus.wf_req_valid    = 4'($urandom);
            bus.wf_req_data     = {$urandom, $urandom, $urandom, $urandom};
            bus.sgpr_req_ready  = ($urandom_range(0, 3) != 0);
            bus.sgpr_resp_valid = (sgpr_pending > 0) && ($urandom_range(0, 1) == 1);
            bus.sgpr_resp_data  = {$urandom, $urandom};
            bus.wf_resp_ready   = 4'($urandom) | 4'($urandom);
            step(1'b0, nul, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
